param_register_file: RTL and testbench

- Next-generation register file for the MIPS-style datapath.
- Width and depth are parametrised.
- Register 0 can optionally be hardwired to zero.
- Adds a write-to-read bypass option and a sequential post-reset clear sweep, with a Busy flag so the pipeline stalls until all entries are zeroed.
- Sits in the decode stage: two combinational read ports, one synchronous write port.

---
 rtl/param_register_file.sv | 96 +++++++++
 tb/tb_param_register_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Parametrised decode-stage register file: two combinational read ports,
// one synchronous write port, optional hardwired zero register, optional
// write-to-read bypass, and a post-reset clear sweep that holds Busy high.
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state, stateNext;
  logic [ADDR_WIDTH-1:0]   ptr, ptrNext;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    wrEn;

  // Architectural write: only when ready, not in reset, and not to a hardwired zero entry
  always_comb begin
    wrEn = RegWrite && !Rst && (state == READY) &&
           !((ZERO_REG != 0) && (WriteRegister == '0));
  end

  // State and sweep pointer register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  // Sweep sequencing: advance ptr until the last entry, then leave CLEAR
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    if (state == CLEAR) begin
      if (ptr == LAST_PTR) stateNext = READY;
      else                 ptrNext   = ptr + PTR_ONE;
    end
  end

  // Memory update: sweep zeroing while clearing, normal writes when ready
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else if (wrEn)      mem[WriteRegister] <= WriteData;
    end
  end

  // Combinational read ports with zero-register and bypass resolution
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (state == READY) begin
      if (!((ZERO_REG != 0) && (ReadRegister1 == '0))) begin
        if ((BYPASS != 0) && wrEn && (WriteRegister == ReadRegister1))
          ReadData1 = WriteData;
        else
          ReadData1 = mem[ReadRegister1];
      end
      if (!((ZERO_REG != 0) && (ReadRegister2 == '0))) begin
        if ((BYPASS != 0) && wrEn && (WriteRegister == ReadRegister2))
          ReadData2 = WriteData;
        else
          ReadData2 = mem[ReadRegister2];
      end
    end
  end

  // Busy flag mirrors the clearing state
  always_comb begin
    Busy = (state == CLEAR);
  end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: one instance with zero register and bypass,
// one with both disabled, checked against an array-based reference model.
module tb_param_register_file;

  logic        Clk;
  logic        Rst;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] rdA1, rdA2, rdB1, rdB2;
  logic        busyA, busyB;

  int checks = 0;
  int errors = 0;

  // Reference model: A = zero reg + bypass, B = plain register file
  logic [31:0] memA [32];
  logic [31:0] memB [32];
  int          remaining = 1;

  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dutA (
    .Clk(Clk), .Rst(Rst),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rdA1), .ReadData2(rdA2), .Busy(busyA)
  );

  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dutB (
    .Clk(Clk), .Rst(Rst),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rdB1), .ReadData2(rdB2), .Busy(busyB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] expA(input logic [4:0] a);
    if (remaining > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (RegWrite && !Rst && WriteRegister == a) return WriteData;
    return memA[a];
  endfunction

  function automatic logic [31:0] expB(input logic [4:0] a);
    if (remaining > 0) return 32'h0;
    return memB[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic expBusy;
    expBusy = (remaining > 0);
    chk("busyA", {31'b0, busyA}, {31'b0, expBusy});
    chk("busyB", {31'b0, busyB}, {31'b0, expBusy});
    chk("A.rd1", rdA1, expA(ReadRegister1));
    chk("A.rd2", rdA2, expA(ReadRegister2));
    chk("B.rd1", rdB1, expB(ReadRegister1));
    chk("B.rd2", rdB2, expB(ReadRegister2));
  endtask

  // Apply the effect of one rising edge to the model
  task automatic modelEdge();
    if (Rst) begin
      remaining = 32;
      for (int unsigned i = 0; i < 32; i++) begin
        memA[i] = 32'h0;
        memB[i] = 32'h0;
      end
    end else if (remaining > 0) begin
      remaining--;
    end else if (RegWrite) begin
      if (WriteRegister != 5'd0) memA[WriteRegister] = WriteData;
      memB[WriteRegister] = WriteData;
    end
  endtask

  // Check outputs with current inputs, then take one clock edge
  task automatic cycle();
    #1;
    checkAll();
    @(posedge Clk);
    modelEdge();
    #1;
  endtask

  task automatic probe(input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
    checkAll();
  endtask

  task automatic readAll();
    RegWrite = 1'b0;
    for (int unsigned i = 0; i < 32; i += 2) probe(5'(i), 5'(i + 1));
  endtask

  initial begin
    Rst = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;

    // Reset for two edges, then the 32-edge sweep
    @(posedge Clk); modelEdge(); #1;
    @(posedge Clk); modelEdge(); #1;
    chk("busy_after_reset", {31'b0, busyA}, 32'h1);
    Rst = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      cycle();
    end
    chk("busy_sweep_done", {31'b0, busyA}, 32'h0);
    readAll();

    // Load regs 8..25 with i*3
    for (int unsigned i = 8; i <= 25; i++) begin
      RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = 32'(i * 3);
      cycle();
    end
    RegWrite = 1'b0;
    for (int unsigned i = 8; i <= 24; i += 2) probe(5'(i), 5'(i + 1));
    probe(5'd8, 5'd25);
    chk("reg8_const", rdA1, 32'h18);
    chk("reg25_const", rdA2, 32'h4B);

    // Bypass: A forwards before the edge, B shows the old value
    RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 32'hDEADBEEF;
    ReadRegister1 = 5'd12; ReadRegister2 = 5'd13;
    #1;
    chk("bypassA_pre", rdA1, 32'hDEADBEEF);
    chk("nobypassB_pre", rdB1, 32'h24);
    cycle();
    RegWrite = 1'b0;
    probe(5'd12, 5'd12);
    chk("bypassB_post", rdB1, 32'hDEADBEEF);

    // Zero register: writes to 0 ignored on A, ordinary on B
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'h12345678;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    #1;
    chk("zeroA_pre", rdA1, 32'h0);
    chk("zeroB_pre", rdB2, 32'h0);
    cycle();
    RegWrite = 1'b0;
    probe(5'd0, 5'd0);
    chk("zeroA_post", rdA2, 32'h0);
    chk("zeroB_post", rdB1, 32'h12345678);

    // Randomised traffic
    for (int unsigned n = 0; n < 400; n++) begin
      Rst           = ($urandom_range(0, 99) == 0);
      RegWrite      = $urandom_range(0, 1);
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      cycle();
    end
    Rst = 1'b0; RegWrite = 1'b0;
    for (int unsigned i = 0; i < 40; i++) cycle();

    // Mid-sweep reset at ptr=10, with a write to reg 9 attempted during sweep
    for (int unsigned i = 0; i < 32; i++) begin
      RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = $urandom | 32'h1;
      cycle();
    end
    RegWrite = 1'b0;
    Rst = 1'b1; cycle();
    Rst = 1'b0;
    for (int unsigned i = 0; i < 10; i++) cycle();
    Rst = 1'b1; cycle();
    Rst = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      RegWrite = (i == 5); WriteRegister = 5'd9; WriteData = 32'hCAFEF00D;
      chk("busy_restart", {31'b0, busyA}, 32'h1);
      cycle();
    end
    RegWrite = 1'b0;
    chk("busy_restart_done", {31'b0, busyB}, 32'h0);
    probe(5'd9, 5'd9);
    chk("reg9_cleared", rdB1, 32'h0);
    readAll();

    // Reset from READY with loaded data
    for (int unsigned i = 0; i < 32; i++) begin
      RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = $urandom | 32'h1;
      cycle();
    end
    RegWrite = 1'b0;
    probe(5'd3, 5'd30);
    Rst = 1'b1; cycle();
    chk("busy_rise", {31'b0, busyA}, 32'h1);
    chk("rd_zero_in_reset", rdB1, 32'h0);
    Rst = 1'b0;
    for (int unsigned i = 0; i < 32; i++) cycle();
    readAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
